// File: rtl/serial_subtractor_8bit_pkg.sv
// rtl/serial_subtractor_8bit_pkg.sv - shared types and constants for the bit-serial subtractor
package serial_subtractor_8bit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int SUB_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int SUB_CNT_W = cnt_width(SUB_WIDTH);

endpackage

// File: rtl/serial_subtractor_8bit_full_adder_1bit.sv
// rtl/serial_subtractor_8bit_full_adder_1bit.sv - single-bit full adder used once per serial step
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// rtl/serial_subtractor_8bit.sv - LSB-first serial subtractor a-b with valid/ready handshakes
module serial_subtractor_8bit
    import serial_subtractor_8bit_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               msb_c_q, msb_c_d;
    logic               fin_q, fin_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               ready_en_q, ready_en_d;

    logic               bit_a;
    logic               bit_nb;
    logic               fa_s;
    logic               fa_cout;

    assign bit_a  = a_q[cnt_q];
    assign bit_nb = ~b_q[cnt_q];

    full_adder_1bit u_fa (
        .a    (bit_a),
        .b    (bit_nb),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        diff_d     = diff_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        msb_c_d    = msb_c_q;
        fin_d      = fin_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;
        ready_en_d = 1'b1;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                // ready_en_q holds in_ready low until the first edge after reset release
                in_ready = ready_en_q;
                if (ready_en_q && in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    fin_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (fin_q) begin
                    // all bits done: publish the result on the edge into DONE
                    diff_d  = res_q;
                    bout_d  = ~carry_q;
                    ovf_d   = msb_c_q ^ carry_q;
                    state_d = DONE;
                end else begin
                    res_d   = {fa_s, res_q[WIDTH-1:1]};
                    carry_d = fa_cout;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        msb_c_d = carry_q;
                        fin_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            diff_q     <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            msb_c_q    <= 1'b0;
            fin_q      <= 1'b0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            diff_q     <= diff_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            msb_c_q    <= msb_c_d;
            fin_q      <= fin_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
            ready_en_q <= ready_en_d;
        end
    end

    assign d    = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// tb/tb_serial_subtractor_8bit.sv - self-checking bench with a behavioural subtraction model
module tb_serial_subtractor_8bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] d;
    logic       bout;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    serial_subtractor_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Behavioural model: busy flag plus edge count since acceptance
    logic       m_started;
    logic       m_busy;
    int         m_age;
    logic [7:0] m_d, m_pd;
    logic       m_b, m_pb;
    logic       m_o, m_po;

    function automatic logic ovf_of(input logic [7:0] x, input logic [7:0] y);
        int r;
        r = int'($signed(x)) - int'($signed(y));
        return (r < -128) || (r > 127);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_busy    <= 1'b0;
            m_age     <= 0;
            m_d       <= 8'h00;
            m_b       <= 1'b0;
            m_o       <= 1'b0;
            m_pd      <= 8'h00;
            m_pb      <= 1'b0;
            m_po      <= 1'b0;
        end else begin
            m_started <= 1'b1;
            if (!m_busy) begin
                if (m_started && in_valid) begin
                    m_busy <= 1'b1;
                    m_age  <= 0;
                    m_pd   <= a - b;
                    m_pb   <= (a < b);
                    m_po   <= ovf_of(a, b);
                end
            end else if (m_age < 9) begin
                m_age <= m_age + 1;
                if (m_age == 8) begin
                    m_d <= m_pd;
                    m_b <= m_pb;
                    m_o <= m_po;
                end
            end else if (out_ready) begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_in_ready", 32'(in_ready), 32'(m_started && !m_busy));
        chk("cmp_out_valid", 32'(out_valid), 32'(m_busy && (m_age == 9)));
        chk("cmp_d", 32'(d), 32'(m_d));
        chk("cmp_bout", 32'(bout), 32'(m_b));
        chk("cmp_ovf", 32'(ovf), 32'(m_o));
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_in_ready: got timeout expected in_ready within 50 cycles");
        end
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input int hold,
                         input bit lit, input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        wait_ready();
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        n = 0;
        while (!out_valid && n < 30) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_out_valid: got timeout expected out_valid within 30 cycles");
        end
        if (lit) begin
            chk("lit_latency", 32'(n), 32'd9);
            chk("lit_d", 32'(d), 32'(ed));
            chk("lit_bout", 32'(bout), 32'(eb));
            chk("lit_ovf", 32'(ovf), 32'(eo));
        end
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            if (lit) chk("hold_d", 32'(d), 32'(ed));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        #2 rst_n = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", 32'(in_ready), 32'd0);

        do_op(8'h05, 8'h03, 0, 1'b1, 8'h02, 1'b0, 1'b0);
        do_op(8'h03, 8'h05, 0, 1'b1, 8'hFE, 1'b1, 1'b0);
        do_op(8'h80, 8'h01, 0, 1'b1, 8'h7F, 1'b0, 1'b1);
        do_op(8'h7F, 8'hFF, 0, 1'b1, 8'h80, 1'b1, 1'b1);
        do_op(8'h00, 8'h00, 5, 1'b1, 8'h00, 1'b0, 1'b0);
        do_op(8'h9C, 8'h21, 1, 1'b1, 8'h7B, 1'b0, 1'b1);

        // Abort mid-shift: four bits processed, bit 4 in flight
        wait_ready();
        in_valid = 1'b1;
        a = 8'h5A;
        b = 8'h33;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_d", 32'(d), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        do_op(8'hFF, 8'h01, 0, 1'b1, 8'hFE, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0, 8'h00, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_8bit.md
SERIAL_SUBTRACTOR_8BIT -- requirements
Module: serial_subtractor_8bit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1: operands a, b are presented.
REQ-005 SHALL have port in_ready  output  1: block accepts operands this cycle.
REQ-006 SHALL have port a  input  WIDTH: minuend.
REQ-007 SHALL have port b  input  WIDTH: subtrahend.
REQ-008 SHALL have port out_valid  output  1: result d, bout, ovf are valid.
REQ-009 SHALL have port out_ready  input  1: consumer takes the result this cycle.
REQ-010 SHALL have port d  output  WIDTH: difference a-b, modulo 2^WIDTH.
REQ-011 SHALL have port bout  output  1: borrow out, 1 when unsigned a < b.
REQ-012 SHALL have port ovf  output  1: signed two's-complement overflow of a-b.

Function
REQ-013 SHALL implement the three-state FSM IDLE, SHIFT, DONE.
REQ-014 In IDLE: in_ready=1, out_valid=0.
REQ-015 In IDLE with in_valid=1: latch a and b, set carry=1 and bit counter=0, then go to SHIFT. This is the accept edge.
REQ-016 In SHIFT: in_ready=0, out_valid=0.
REQ-017 In SHIFT, each cycle processes bit i = counter, LSB first.
  - result bit = a[i] XOR NOT b[i] XOR carry.
  - carry <= majority(a[i], NOT b[i], carry).
  - counter <= counter + 1.
REQ-018 SHALL record the carry into bit WIDTH-1 during the final SHIFT cycle; it is used for ovf.
REQ-019 After exactly WIDTH SHIFT cycles, go to DONE; out_valid rises WIDTH+1 edges after the accept edge.
REQ-020 On entry to DONE, set the outputs as follows:
  - d = assembled result.
  - bout = NOT final carry.
  - ovf = carry into MSB XOR final carry.
REQ-021 In DONE: out_valid=1; d, bout and ovf SHALL be held stable until the handshake completes.
REQ-022 In DONE with out_ready=1: go to IDLE; in_ready reasserts on the next cycle. No accept occurs in the same cycle as the result handshake.
REQ-023 SHALL ignore in_valid, a and b outside IDLE; changes to operands after acceptance SHALL NOT affect the result.
REQ-024 While out_ready=0 in DONE, SHALL remain in DONE indefinitely with no loss of the result.
REQ-025 d, bout and ovf SHALL retain the last result in IDLE and SHIFT; they are zero after reset.

Reset
REQ-026 On rst_n=0, asynchronously:
  - state = IDLE.
  - counter, carry and operand registers = 0.
  - d = 0, bout = 0, ovf = 0, out_valid = 0.
REQ-027 in_ready SHALL be 0 while rst_n=0 and 1 from the first clock edge after rst_n deasserts.
REQ-028 Reset asserted in SHIFT or DONE SHALL abort the operation; no out_valid pulse follows for that operand pair.

Structure
REQ-029 The shared package SHALL hold:
  - state enum (IDLE, SHIFT, DONE).
  - WIDTH default constant.
  - counter width constant = clog2(WIDTH).
REQ-030 The per-bit arithmetic SHALL be one instance of sub-module full_adder_1bit (a, b, cin -> s, cout), fed NOT b[i].
REQ-031 The FSM, counter, shift register and output registers SHALL be in serial_subtractor_8bit.

Verification
REQ-032 a=0x05, b=0x03 -> d=0x02, bout=0, ovf=0; out_valid 9 edges after the accept edge.
REQ-033 a=0x03, b=0x05 -> d=0xFE, bout=1, ovf=0.
REQ-034 Signed overflow cases:
  - a=0x80, b=0x01 -> d=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF -> d=0x80, bout=1, ovf=1.
REQ-035 Backpressure: a=0x00, b=0x00 with out_ready=0 for 5 cycles in DONE -> out_valid held, d=0x00 stable, in_ready=0 throughout.
REQ-036 Operand stability: operands change after accept -> result matches the latched pair.
REQ-037 Reset mid-operation: rst_n pulsed low at SHIFT bit 4 -> d=0 and out_valid=0 immediately; next transaction 0xFF-0x01 -> d=0xFE.
